// File: rtl/multiplication_pkg.sv
// ============================================================================
// Module  : multiplication_pkg
// Brief   : State encoding and default width shared by the multiply datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multiplication_pkg;

  localparam int c_default_width = 32;

  // Encodings match the Division unit so both FSMs decode identically.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/multiplication.sv
// ============================================================================
// Module  : multiplication
// Brief   : Sequential unsigned shift-and-add multiplier, WIDTH steps per op.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplication
  import multiplication_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_mcand;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shift;

  // The extra acc bit keeps the carry of the step add, so all-ones operands do not overflow.
  assign w_sum   = r_acc + {1'b0, (r_mplr[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_shift = {w_sum, r_mplr} >> 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= '0;
            r_mplr  <= b;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc  <= w_shift[2*WIDTH:WIDTH];
          r_mplr <= w_shift[WIDTH-1:0];
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_hi    <= w_shift[2*WIDTH-1:WIDTH];
            r_lo    <= w_shift[WIDTH-1:0];
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == BUSY);
  assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_multiplication.sv
// ============================================================================
// Module  : tb_multiplication
// Brief   : Scoreboard bench for the shift-and-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplication;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [63:0]      exp_q[$];
  int               cycle     = 0;
  int               last_done = -1;
  int               busy_run  = 0;
  bit               check_period = 1'b0;
  logic [WIDTH-1:0] last_lo = '0;

  multiplication #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clock) begin
    logic [63:0] e;
    cycle++;
    if (!check_period) last_done = -1;
    if (!reset) begin
      busy_run  = 0;
      last_done = -1;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        check("busy_cycles", 64'(busy_run), 64'(WIDTH));
        busy_run = 0;
        if (check_period && last_done >= 0)
          check("done_period", 64'(cycle - last_done), 64'(WIDTH + 2));
        last_done = cycle;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got hi=%0h lo=%0h, expected no pulse", hi, lo);
        end else begin
          e = exp_q.pop_front();
          check("product", {hi, lo}, e);
          last_lo = lo;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((busy || done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b done=%0b, expected idle within 200 cycles", busy, done);
    end
  endtask

  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit expect_it);
    wait_idle();
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_it) exp_q.push_back(64'(x) * 64'(y));
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    // Scramble the operands mid-operation; the captured values must be used.
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  initial begin
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // Release reset with start already high: launch on the first edge.
    @(negedge clock);
    a     = 32'd9;
    b     = 32'd5;
    start = 1'b1;
    exp_q.push_back(64'd45);
    reset = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("launch_after_release", 64'(busy), 64'd1);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    launch(32'h1234_5678, 32'd0, 1'b1);
    launch(32'd0, 32'd7, 1'b1);

    // Start held high: back-to-back ops; a change mid-BUSY only affects the next op.
    wait_idle();
    check_period = 1'b1;
    a     = 32'd6;
    b     = 32'd7;
    start = 1'b1;
    exp_q.push_back(64'd42);
    repeat (5) @(negedge clock);
    a = 32'd3;
    repeat (4) exp_q.push_back(64'd21);
    repeat (132) @(negedge clock);
    start = 1'b0;
    wait_idle();
    check_period = 1'b0;

    for (int i = 0; i < 20; i++)
      launch(WIDTH'($urandom), (i % 5 == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom), 1'b1);

    // Round trip with Division(9,5): q=1, r=4.
    launch(32'd1, 32'd5, 1'b1);
    wait_idle();
    check("round_trip", 64'(last_lo) + 64'd4, 64'd9);

    // Abort mid-operation: no done pulse, outputs cleared.
    launch(32'd100, 32'd100, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_release", 64'(busy), 64'd0);
    launch(32'd100, 32'd100, 1'b1);
    wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
